maze_solver_param: RTL
======================

Name: maze_solver_param

Overview:
- Parametrised next-generation rat-in-maze solver with an internal, loadable maze store of ROWS x COLS cells (1 = wall, 0 = free), a direction stack, a visited map and a search FSM.
- Searches depth-first from cell (0,0) to cell (ROWS-1, COLS-1), backtracking through the stack.
- After success, replays the found path one move per cycle on request.
- Sits between the host/testbench (maze load, start, run) and any downstream move consumer.

Parameters:
- ROW_BITS, 4, row index width; ROWS = 2**ROW_BITS.
- COL_BITS, 4, column index width; COLS = 2**COL_BITS.
- DEPTH, ROWS*COLS, stack depth in entries of 2 bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ld_en  in  1  write one maze cell this cycle; honoured only in IDLE, DONE or FAIL.
- ld_addr  in  ROW_BITS+COL_BITS  cell address, row-major: row*COLS+col.
- ld_data  in  1  cell value, 1 = wall.
- start  in  1  one-cycle pulse that begins a search.
- run  in  1  one-cycle pulse that begins path replay; honoured only in DONE.
- busy  out  1  high while searching or replaying.
- done  out  1  path found.
- fail  out  1  no path exists.
- move  out  1  replay step valid.
- move_dir  out  2  replay step direction: 0 up, 1 right, 2 down, 3 left.
- move_row  out  ROW_BITS  row reached by this replay step.
- move_col  out  COL_BITS  column reached by this replay step.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Asserting rst forces state IDLE, and busy, done, fail, move, move_dir, move_row, move_col, stack pointer and position all to 0.
  - The visited map is cleared; maze contents are retained.
  - Reset asserted mid-search or mid-replay aborts immediately with no further move pulses.
- FSM states: IDLE, INIT, TRY, ADV, BACK, DONE, FAIL, REPLAY.
- IDLE/DONE/FAIL + start → INIT. The visited map is cleared in parallel in the same edge; done and fail drop; busy rises. start in any other state is ignored.
- INIT (1 cycle):
  - If cell (0,0) is a wall → FAIL.
  - Otherwise mark (0,0) visited, set pos = (0,0), dir = 0, sp = 0.
  - If ROWS = COLS = 1 → DONE; else → TRY.
- TRY (1 cycle per direction): test neighbour in direction dir; it is a candidate only if it is in bounds, not a wall and not visited.
  - Candidate → ADV.
  - Not a candidate and dir < 3 → dir+1, stay in TRY.
  - Not a candidate and dir = 3 → BACK.
- ADV (1 cycle): push dir, sp+1, move pos to the neighbour, mark it visited, dir = 0.
  - If the new pos is the goal → DONE; else → TRY.
- BACK (1 cycle):
  - sp = 0 → FAIL.
  - Otherwise pop d, sp-1, move pos opposite to d (d xor 2).
  - d = 3 → BACK again; else dir = d+1 and → TRY.
- Boundary conditions:
  - Out-of-bounds tests cover row 0 up, row ROWS-1 down, col 0 left and col COLS-1 right.
  - The stack cannot overflow: visited marking bounds its depth at ROWS*COLS-1.
- DONE/FAIL: busy = 0; done (or fail) is held high until the next start or reset.
- DONE + run → REPLAY, busy = 1, replay pointer rp = 0, replay position = (0,0).
- REPLAY:
  - Each cycle with rp < sp: move = 1, move_dir = stack[rp], move_row/move_col = position after applying that step; rp+1.
  - When rp = sp: move = 0, busy = 0, return to DONE. Exactly sp move pulses, on consecutive cycles starting the cycle after run.
  - A path of length 0 (ROWS = COLS = 1) returns to DONE with no moves.
  - run and start are ignored during REPLAY.
- ld_en outside the permitted states is ignored. start and ld_en in the same cycle: the load is applied first, then the search starts with the updated maze.
- Every output is registered.

Optional Feature:
- Macro: PATH_LEN_EN.
- Defined: adds output path_len (ROW_BITS+COL_BITS+1 bits) and output explore_cnt (16 bits, saturating at 16'hFFFF).
  - path_len = sp, captured on entry to DONE; 0 on fail or reset.
  - explore_cnt counts ADV cycles since the last start, held after DONE/FAIL.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- ROW_BITS = COL_BITS = 2, all cells free, start → done after INIT + search. Then run → 6 moves with dirs R,R,R,D,D,D, positions (0,1),(0,2),(0,3),(1,3),(2,3),(3,3); busy low after the 6th move; path_len = 6.
- 4x4 maze, walls at (0,1) and (1,0), start → fail = 1, done = 0, no moves on run; path_len = 0.
- 4x4 maze, wall at (0,0) → fail asserted 2 cycles after start.
- 4x4 maze with dead-end branch: walls at (1,0),(1,1),(1,2),(2,3),(3,2).
  - Forces backtrack; the solver fails (goal unreachable).
  - Remove wall (2,3) via ld_en in FAIL, restart → done with path R,R,R,D,D,D.
- rst deasserted-then-asserted during TRY → all outputs 0 on the same edge. Resume with start → identical result to the uninterrupted run.
- start and ld_en pulsed during busy → ignored (maze unchanged, search result unchanged); run in IDLE → no moves.

Source files
------------

// File: rtl/maze_solver_param.sv
// Depth-first rat-in-maze solver: loadable wall map, direction stack, visited map, path replay.
// Define PATH_LEN_EN to add the path_len and explore_cnt outputs.
module maze_solver_param #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 4,
  parameter int DEPTH    = (2**ROW_BITS) * (2**COL_BITS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld_en,
  input  logic [ROW_BITS+COL_BITS-1:0] ld_addr,
  input  logic                         ld_data,
  input  logic                         start,
  input  logic                         run,
  output logic                         busy,
  output logic                         done,
  output logic                         fail,
  output logic                         move,
  output logic [1:0]                   move_dir,
  output logic [ROW_BITS-1:0]          move_row,
  output logic [COL_BITS-1:0]          move_col
`ifdef PATH_LEN_EN
  ,
  output logic [ROW_BITS+COL_BITS:0]   path_len,
  output logic [15:0]                  explore_cnt
`endif
);

  localparam int AW     = ROW_BITS + COL_BITS;
  localparam int CELLS  = 2**AW;
  localparam int SPW    = AW + 1;
  localparam bit SINGLE = (ROW_BITS == 0) && (COL_BITS == 0);
  localparam logic [AW-1:0] GOAL = '1;

  typedef enum logic [2:0] {IDLE, INIT, TRY, ADV, BACK, DONE, FAIL, REPLAY} state_t;

  state_t              state, state_d;
  logic [CELLS-1:0]    maze;
  logic [CELLS-1:0]    visited;
  logic [1:0]          stack [DEPTH];
  logic [ROW_BITS-1:0] pos_row, rrow;
  logic [COL_BITS-1:0] pos_col, rcol;
  logic [1:0]          dir;
  logic [SPW-1:0]      sp, rp;

  logic [AW-1:0]       nb, bk, rnext, top_idx;
  logic [1:0]          top, rdir;
  logic                cand, at_goal, ld_ok;
  logic                busy_d, done_d, fail_d, move_d;
  logic [1:0]          move_dir_d;
  logic [ROW_BITS-1:0] move_row_d;
  logic [COL_BITS-1:0] move_col_d;

  // Cell address {row,col} reached by one step in direction d.
  function automatic logic [AW-1:0] step(input logic [ROW_BITS-1:0] r,
                                         input logic [COL_BITS-1:0] c,
                                         input logic [1:0] d);
    logic [ROW_BITS-1:0] nr;
    logic [COL_BITS-1:0] nc;
    nr = r;
    nc = c;
    case (d)
      2'd0:    nr = r - ROW_BITS'(1);
      2'd1:    nc = c + COL_BITS'(1);
      2'd2:    nr = r + ROW_BITS'(1);
      default: nc = c - COL_BITS'(1);
    endcase
    return {nr, nc};
  endfunction

  function automatic logic in_bounds(input logic [ROW_BITS-1:0] r,
                                     input logic [COL_BITS-1:0] c,
                                     input logic [1:0] d);
    case (d)
      2'd0:    return r != '0;
      2'd1:    return c != '1;
      2'd2:    return r != '1;
      default: return c != '0;
    endcase
  endfunction

  assign nb      = step(pos_row, pos_col, dir);
  assign cand    = in_bounds(pos_row, pos_col, dir) && !maze[nb] && !visited[nb];
  assign at_goal = (nb == GOAL);
  assign top_idx = sp[AW-1:0] - AW'(1);
  assign top     = stack[top_idx];
  assign bk      = step(pos_row, pos_col, top ^ 2'd2);
  assign rdir    = stack[rp[AW-1:0]];
  assign rnext   = step(rrow, rcol, rdir);
  assign ld_ok   = (state == IDLE) || (state == DONE) || (state == FAIL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE, FAIL: if (start) state_d = INIT;
      DONE: begin
        if (start)    state_d = INIT;
        else if (run) state_d = REPLAY;
      end
      INIT: begin
        if (maze[0])     state_d = FAIL;
        else if (SINGLE) state_d = DONE;
        else             state_d = TRY;
      end
      TRY: begin
        if (cand)            state_d = ADV;
        else if (dir == 2'd3) state_d = BACK;
      end
      ADV:  state_d = at_goal ? DONE : TRY;
      BACK: begin
        if (sp == '0)        state_d = FAIL;
        else if (top != 2'd3) state_d = TRY;
      end
      REPLAY: if (rp >= sp) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the state being entered, so they track state one-for-one.
  always_comb begin
    busy_d     = (state_d == INIT) || (state_d == TRY) || (state_d == ADV) ||
                 (state_d == BACK) || (state_d == REPLAY);
    done_d     = (state_d == DONE) || (state_d == REPLAY);
    fail_d     = (state_d == FAIL);
    move_d     = 1'b0;
    move_dir_d = move_dir;
    move_row_d = move_row;
    move_col_d = move_col;
    if (state == REPLAY && rp < sp) begin
      move_d                   = 1'b1;
      move_dir_d               = rdir;
      {move_row_d, move_col_d} = rnext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
      move     <= 1'b0;
      move_dir <= '0;
      move_row <= '0;
      move_col <= '0;
      pos_row  <= '0;
      pos_col  <= '0;
      dir      <= '0;
      sp       <= '0;
      rp       <= '0;
      rrow     <= '0;
      rcol     <= '0;
      visited  <= '0;
    end else begin
      busy     <= busy_d;
      done     <= done_d;
      fail     <= fail_d;
      move     <= move_d;
      move_dir <= move_dir_d;
      move_row <= move_row_d;
      move_col <= move_col_d;
      case (state)
        IDLE, FAIL: if (start) visited <= '0;
        DONE: begin
          if (start) visited <= '0;
          else if (run) begin
            rp   <= '0;
            rrow <= '0;
            rcol <= '0;
          end
        end
        INIT: begin
          pos_row <= '0;
          pos_col <= '0;
          dir     <= '0;
          sp      <= '0;
          if (!maze[0]) visited[0] <= 1'b1;
        end
        TRY: if (!cand) dir <= dir + 2'd1;
        ADV: begin
          {pos_row, pos_col} <= nb;
          visited[nb]        <= 1'b1;
          sp                 <= sp + SPW'(1);
          dir                <= '0;
        end
        BACK: if (sp != '0) begin
          {pos_row, pos_col} <= bk;
          sp                 <= sp - SPW'(1);
          dir                <= top + 2'd1;
        end
        REPLAY: if (rp < sp) begin
          rp           <= rp + SPW'(1);
          {rrow, rcol} <= rnext;
        end
        default: ;
      endcase
    end
  end

  // Maze and stack are plain storage; the maze deliberately survives reset.
  always_ff @(posedge clk) begin
    if (ld_en && ld_ok) maze[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (state == ADV) stack[sp[AW-1:0]] <= dir;
  end

`ifdef PATH_LEN_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      path_len    <= '0;
      explore_cnt <= '0;
    end else if (ld_ok && start) begin
      path_len    <= '0;
      explore_cnt <= '0;
    end else if (state == ADV) begin
      explore_cnt <= sat_inc16(explore_cnt);
      if (at_goal) path_len <= sp + SPW'(1);
    end
  end
`endif

endmodule
